// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds func3 encodings, FSM states and the latency counter width.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU datapath and the data memory.
// master = CPU side, slave = memory responder side.
interface dmem_if;

    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        stall;
    logic        err;

    modport master (
        output mem_read, mem_write, func3, addr, write_data,
        input  read_data, ready, stall, err
    );

    modport slave (
        input  mem_read, mem_write, func3, addr, write_data,
        output read_data, ready, stall, err
    );

endinterface

// File: rtl/dmem_responder_lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; size comes from func3[1:0], sign from func3[2].
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic        misalign_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign half_v = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Store path: lane enables, replicated data, alignment check
    always_comb begin
        be_o       = 4'b0000;
        wword_o    = wdata_i;
        misalign_o = 1'b0;
        case (func3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            2'b10: begin
                be_o       = 4'b1111;
                misalign_o = |addr_lo_i;
            end
            default: ;
        endcase
    end

    // Load path: select lane and sign/zero extend
    always_comb begin
        rdata_o = 32'h0;
        case (func3_i)
            F3_B:    rdata_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    rdata_o = {{16{half_v[15]}}, half_v};
            F3_W:    rdata_o = rword_i;
            F3_BU:   rdata_o = {24'h0, byte_v};
            F3_HU:   rdata_o = {16'h0, half_v};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data memory for RV32I loads/stores with stall and error.
// Request is captured in IDLE; response strobes one cycle in DONE.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input logic  clk,
    input logic  rst,
    dmem_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rd_q, wr_q;
    logic [2:0]         f3_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        read_data_q;
    logic               err_q;
    logic [31:0]        mem_q [DEPTH];

    logic               req;
    logic               ready;
    logic [AW-1:0]      word_idx;
    logic               oor;
    logic               bad_f3;
    logic               misalign;
    logic               req_err;
    logic [3:0]         be;
    logic [31:0]        wword;
    logic [31:0]        ext;

    assign req      = bus.mem_read | bus.mem_write;
    assign ready    = (state_q == DONE);
    assign word_idx = addr_q[AW+1:2];
    assign oor      = |addr_q[31:AW+2];

    lsu_align u_align (
        .addr_lo_i  (addr_q[1:0]),
        .func3_i    (f3_q),
        .wdata_i    (wdata_q),
        .rword_i    (mem_q[word_idx]),
        .be_o       (be),
        .wword_o    (wword),
        .misalign_o (misalign),
        .rdata_o    (ext)
    );

    // Classify the captured request as illegal or legal
    always_comb begin
        bad_f3 = 1'b0;
        if (rd_q)
            bad_f3 = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
        else if (wr_q)
            bad_f3 = !((f3_q == F3_B) || (f3_q == F3_H) || (f3_q == F3_W));
        req_err = (rd_q & wr_q) | misalign | oor | bad_f3;
    end

    // Next-state and latency counter logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    count_d = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (count_q == '0)
                    state_d = DONE;
                else
                    count_d = count_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM, request capture and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            read_data_q <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (state_q == IDLE && req) begin
                rd_q    <= bus.mem_read;
                wr_q    <= bus.mem_write;
                f3_q    <= bus.func3;
                addr_q  <= bus.addr;
                wdata_q <= bus.write_data;
            end
            if (state_q == BUSY && count_q == '0) begin
                err_q <= req_err;
                if (req_err)
                    read_data_q <= 32'h0;
                else if (rd_q)
                    read_data_q <= ext;
            end
        end
    end

    // Commit store lanes at the edge that closes the DONE cycle
    always_ff @(posedge clk) begin
        if (!rst && ready && wr_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem_q[word_idx][i*8 +: 8] <= wword[i*8 +: 8];
            end
        end
    end

    assign bus.ready     = ready;
    assign bus.err       = ready & err_q;
    assign bus.read_data = read_data_q;
    assign bus.stall     = req & ~ready;

endmodule
